occupancy_display_scanner: RTL

// - Downstream consumer of the occupancy grid: on request, rasters every cell of the

---
 rtl/hector_display_pkg.sv | 22 ++
 rtl/occupancy_colour_map.sv | 27 ++
 rtl/occupancy_display_scanner.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hector_display_pkg.sv
// Shared definitions for the occupancy display path.
// - display_state_t: scanner FSM states.
// - COLOUR_*: 3-bit {R,G,B} plot colours for free / occupied / unknown cells.
// - GRID_W / GRID_H: grid dimensions shared with the occupancy and bresenham blocks.
package hector_display_pkg;

    localparam int GRID_W = 160;
    localparam int GRID_H = 120;

    localparam logic [2:0] COLOUR_FREE    = 3'b111;
    localparam logic [2:0] COLOUR_OCC     = 3'b000;
    localparam logic [2:0] COLOUR_UNKNOWN = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        SCAN,
        DRAIN,
        DONE
    } display_state_t;

endpackage

// File: rtl/occupancy_colour_map.sv
// Combinational log-odds to colour mapping.
// Ports:
//   data    in   DATA_W  unsigned log-odds cell value (128 = unknown)
//   colour  out  3       COLOUR_FREE below FREE_TH, COLOUR_OCC at/above OCC_TH,
//                        COLOUR_UNKNOWN in between
module occupancy_colour_map
    import hector_display_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] FREE_TH = DATA_W'(96),
    parameter logic [DATA_W-1:0] OCC_TH  = DATA_W'(160)
) (
    input  logic [DATA_W-1:0] data,
    output logic [2:0]        colour
);

    always_comb begin
        if (data < FREE_TH) begin
            colour = COLOUR_FREE;
        end else if (data >= OCC_TH) begin
            colour = COLOUR_OCC;
        end else begin
            colour = COLOUR_UNKNOWN;
        end
    end

endmodule

// File: rtl/occupancy_display_scanner.sv
// Rasters the whole occupancy grid on request and plots one pixel per cell.
// Ownership of the occupancy index path is negotiated with grid_request/grid_grant;
// losing it mid-frame rewinds the raster so no cell is skipped or plotted twice.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// REQUEST | asking for the index path, waiting for grant and !busy
// SCAN    | issuing one cell address per cycle in raster order
// DRAIN   | no new issues, waiting for in-flight reads to plot
// DONE    | one-cycle frame_done
//
// Ports:
//   clock, reset_n   system clock, asynchronous active-low reset
//   start            one-cycle frame request, ignored while busy
//   grid_grant       index path granted to the display
//   occupancy_busy   occupancy module busy, reads not allowed
//   occupancy_data   cell value, valid READ_LAT cycles after the index
//   grid_request     index path requested (REQUEST/SCAN/DRAIN)
//   x_display/y_display  read index, held outside SCAN
//   vga_x/vga_y/vga_colour/vga_plot  pixel write, zero when not plotting
//   busy             frame in progress
//   frame_done       one-cycle pulse after the last plot
module occupancy_display_scanner #(
    parameter int                GRID_W   = hector_display_pkg::GRID_W,
    parameter int                GRID_H   = hector_display_pkg::GRID_H,
    parameter int                X_W      = 8,
    parameter int                Y_W      = 7,
    parameter int                DATA_W   = 8,
    parameter int                READ_LAT = 1,
    parameter logic [DATA_W-1:0] FREE_TH  = DATA_W'(96),
    parameter logic [DATA_W-1:0] OCC_TH   = DATA_W'(160)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              grid_grant,
    input  logic              occupancy_busy,
    input  logic [DATA_W-1:0] occupancy_data,
    output logic              grid_request,
    output logic [X_W-1:0]    x_display,
    output logic [Y_W-1:0]    y_display,
    output logic [X_W-1:0]    vga_x,
    output logic [Y_W-1:0]    vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic              busy,
    output logic              frame_done
);

    import hector_display_pkg::*;

    localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

    display_state_t state, state_nxt;

    logic [X_W-1:0] cnt_x, x_hold;
    logic [Y_W-1:0] cnt_y, y_hold;

    // Read pipeline: index 0 is the newest issue, READ_LAT-1 lines up with occupancy_data.
    logic [READ_LAT-1:0] pipe_v;
    logic [X_W-1:0]      pipe_x [READ_LAT];
    logic [Y_W-1:0]      pipe_y [READ_LAT];

    logic           grant_lost;
    logic           issue;
    logic           last_cell;
    logic           plot;
    logic           older_pending;
    logic           rw_valid;
    logic [X_W-1:0] rw_x;
    logic [Y_W-1:0] rw_y;
    logic [2:0]     map_colour;

    assign grant_lost = ((state == SCAN) || (state == DRAIN)) && (!grid_grant || occupancy_busy);
    assign issue      = (state == SCAN) && !grant_lost;
    assign last_cell  = (cnt_x == X_LAST) && (cnt_y == Y_LAST);
    assign plot       = pipe_v[READ_LAT-1] && !grant_lost;

    // Oldest valid in-flight entry: the highest valid index wins.
    always_comb begin
        rw_valid      = 1'b0;
        rw_x          = cnt_x;
        rw_y          = cnt_y;
        older_pending = 1'b0;
        for (int i = 0; i < READ_LAT; i++) begin
            if (pipe_v[i]) begin
                rw_valid = 1'b1;
                rw_x     = pipe_x[i];
                rw_y     = pipe_y[i];
            end
        end
        for (int i = 0; i < READ_LAT - 1; i++) begin
            older_pending = older_pending | pipe_v[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grid_request = 1'b0;
        busy         = 1'b1;
        frame_done   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = REQUEST;
                end
            end
            REQUEST: begin
                grid_request = 1'b1;
                if (grid_grant && !occupancy_busy) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                grid_request = 1'b1;
                if (grant_lost) begin
                    state_nxt = REQUEST;
                end else if (last_cell) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                grid_request = 1'b1;
                if (grant_lost) begin
                    state_nxt = REQUEST;
                end else if (!older_pending) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Raster counter: cleared on a new frame, rewound on grant loss, held on the last cell.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if ((state == IDLE) && start) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if (grant_lost) begin
            if (rw_valid) begin
                cnt_x <= rw_x;
                cnt_y <= rw_y;
            end
        end else if (issue && !last_cell) begin
            if (cnt_x == X_LAST) begin
                cnt_x <= '0;
                cnt_y <= cnt_y + Y_W'(1);
            end else begin
                cnt_x <= cnt_x + X_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_hold <= '0;
            y_hold <= '0;
        end else if (state == SCAN) begin
            x_hold <= cnt_x;
            y_hold <= cnt_y;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_x[i] <= '0;
                pipe_y[i] <= '0;
            end
        end else if (grant_lost) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= issue;
            pipe_x[0] <= cnt_x;
            pipe_y[0] <= cnt_y;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_x[i] <= pipe_x[i-1];
                pipe_y[i] <= pipe_y[i-1];
            end
        end
    end

    occupancy_colour_map #(
        .DATA_W  (DATA_W),
        .FREE_TH (FREE_TH),
        .OCC_TH  (OCC_TH)
    ) u_colour_map (
        .data   (occupancy_data),
        .colour (map_colour)
    );

    assign x_display  = (state == SCAN) ? cnt_x : x_hold;
    assign y_display  = (state == SCAN) ? cnt_y : y_hold;
    assign vga_plot   = plot;
    assign vga_x      = plot ? pipe_x[READ_LAT-1] : '0;
    assign vga_y      = plot ? pipe_y[READ_LAT-1] : '0;
    assign vga_colour = plot ? map_colour : 3'b000;

endmodule
